// File: rtl/psum_accumulator_if.sv
// Stream bundle between the systolic array, the accumulator and the ppu:
// array row beats in, header plus drained buffer rows out.
interface psum_accumulator_if #(
    parameter int LANES = 16,
    parameter int IN_W  = 20,
    parameter int ACC_W = 24
);
    logic                   in_valid;
    logic [LANES*IN_W-1:0]  in_data;
    logic                   in_ready;
    logic                   out_valid;
    logic [LANES*ACC_W-1:0] partial_sum;
    logic                   row_valid;

    modport master (
        output in_valid, in_data,
        input  in_ready, out_valid, partial_sum, row_valid
    );
    modport slave (
        input  in_valid, in_data,
        output in_ready, out_valid, partial_sum, row_valid
    );
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates K-tiles of 16-lane partial-sum rows into a saturating int24
// buffer, then streams it to the ppu as a header pulse plus 16 rows.
module psum_lane #(
    parameter int IN_W  = 20,
    parameter int ACC_W = 24
) (
    input  logic             first,
    input  logic [ACC_W-1:0] acc,
    input  logic [IN_W-1:0]  din,
    output logic [ACC_W-1:0] res,
    output logic             sat
);
    logic [ACC_W:0] sum;

    always_comb begin
        sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-IN_W){din[IN_W-1]}}, din};
        sat = 1'b0;
        res = sum[ACC_W-1:0];
        if (first) begin
            res = {{(ACC_W-IN_W){din[IN_W-1]}}, din};
        end else if (sum[ACC_W] != sum[ACC_W-1]) begin
            // 25-bit sum left the int24 range: clamp toward its true sign
            sat = 1'b1;
            res = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
endmodule

module psum_accumulator #(
    parameter int LANES = 16,
    parameter int ROWS  = 16,
    parameter int IN_W  = 20,
    parameter int ACC_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          num_tiles,
    psum_accumulator_if.slave   bus,
    output logic                busy,
    output logic                done,
    output logic                overflow
);
    localparam int RW = $clog2(ROWS);

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_HDR, S_DRAIN, S_DONE} state_t;

    state_t                              state;
    logic [RW-1:0]                       row;
    logic [7:0]                          tile;
    logic [7:0]                          tiles_m1;
    logic [ROWS-1:0][LANES*ACC_W-1:0]    acc_buf;
    logic [LANES*ACC_W-1:0]              ps_q;
    logic [LANES-1:0][ACC_W-1:0]         lane_res;
    logic [LANES-1:0]                    lane_sat;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        psum_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane (
            .first (tile == 8'd0),
            .acc   (acc_buf[row][i*ACC_W +: ACC_W]),
            .din   (bus.in_data[i*IN_W +: IN_W]),
            .res   (lane_res[i]),
            .sat   (lane_sat[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            row      <= '0;
            tile     <= '0;
            tiles_m1 <= '0;
            overflow <= 1'b0;
            ps_q     <= '0;
            acc_buf  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    tiles_m1 <= (num_tiles == 8'd0) ? 8'd0 : num_tiles - 8'd1;
                    row      <= '0;
                    tile     <= '0;
                    overflow <= 1'b0;
                    state    <= S_ACCUM;
                end
                S_ACCUM: if (bus.in_valid) begin
                    acc_buf[row] <= lane_res;
                    if (|lane_sat) overflow <= 1'b1;
                    row <= row + RW'(1);
                    if (row == RW'(ROWS-1)) begin
                        tile <= tile + 8'd1;
                        if (tile == tiles_m1) state <= S_HDR;
                    end
                end
                S_HDR: begin
                    ps_q  <= acc_buf[row];
                    row   <= row + RW'(1);
                    state <= S_DRAIN;
                end
                // row has wrapped to 0 once the last buffer row is on the output
                S_DRAIN: if (row == '0) begin
                    ps_q  <= '0;
                    state <= S_DONE;
                end else begin
                    ps_q <= acc_buf[row];
                    row  <= row + RW'(1);
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state == S_ACCUM);
    assign bus.out_valid   = (state == S_HDR);
    assign bus.row_valid   = (state == S_DRAIN);
    assign bus.partial_sum = ps_q;
    assign busy            = (state != S_IDLE);
    assign done            = (state == S_DONE);
endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: a lane model fills a queue of
// expected rows that a negedge monitor pops as the drain runs.
module tb_psum_accumulator;
    localparam int LANES = 16;
    localparam int ROWS  = 16;
    localparam int IN_W  = 20;
    localparam int ACC_W = 24;
    typedef logic [LANES*ACC_W-1:0] row_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] num_tiles = 8'd0;
    logic       busy, done, overflow;

    psum_accumulator_if #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W)) bus();

    psum_accumulator #(.LANES(LANES), .ROWS(ROWS), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
        .bus(bus), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   rows_seen = 0;
    row_t sbq[$];
    int   model[ROWS][LANES];

    always @(negedge clk) begin
        row_t e;
        if (bus.row_valid === 1'b1) begin
            rows_seen++;
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL row_extra: drain row %0d with no expected row queued", rows_seen);
            end else begin
                e = sbq.pop_front();
                if (bus.partial_sum !== e) begin
                    bad++;
                    $display("FAIL row_data: row %0d got %h want %h", rows_seen - 1, bus.partial_sum, e);
                end
            end
        end else begin
            total++;
            if (bus.partial_sum !== '0) begin
                bad++;
                $display("FAIL ps_idle_zero: got %h want 0", bus.partial_sum);
            end
        end
    end

    function automatic int sat24(input int x);
        if (x > 8388607) return 8388607;
        if (x < -8388608) return -8388608;
        return x;
    endfunction

    task automatic start_run(input logic [7:0] n);
        num_tiles = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rows_seen = 0;
    endtask

    // Drives tiles*ROWS beats (gap idle cycles between beats) and queues the
    // expected rows; returns in the cycle after the last accepted beat.
    task automatic feed_run(input int tiles, input int val, input bit seq, input int gap);
        logic [LANES*IN_W-1:0] d;
        logic [IN_W-1:0]       l20;
        logic [31:0]           m;
        row_t                  e;
        int                    v;
        for (int t = 0; t < tiles; t++) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int i = 0; i < LANES; i++) begin
                    v = seq ? r * 16 + i : val;
                    l20 = v[IN_W-1:0];
                    d[i*IN_W +: IN_W] = l20;
                    model[r][i] = (t == 0) ? v : sat24(model[r][i] + v);
                end
                bus.in_data  = d;
                bus.in_valid = 1'b1;
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                if (gap > 0 && !(t == tiles - 1 && r == ROWS - 1))
                    repeat (gap) begin @(posedge clk); #1; end
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int i = 0; i < LANES; i++) begin
                m = model[r][i];
                e[i*ACC_W +: ACC_W] = m[ACC_W-1:0];
            end
            sbq.push_back(e);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.row_valid, busy, done, overflow} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {bus.in_ready, bus.out_valid, bus.row_valid, busy, done, overflow});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_single_tile();
        start_run(8'd1);
        total++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL single_start: in_ready=%b busy=%b want 1 1", bus.in_ready, busy);
        end
        feed_run(1, 0, 1'b1, 0);
        total++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.row_valid !== 1'b0) begin
            bad++; $display("FAIL single_hdr: out_valid=%b in_ready=%b row_valid=%b want 1 0 0",
                            bus.out_valid, bus.in_ready, bus.row_valid);
        end
        repeat (16) begin @(posedge clk); #1; end
        total++;
        if (bus.row_valid !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL single_row15: row_valid=%b done=%b want 1 0", bus.row_valid, done);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b1 || bus.row_valid !== 1'b0 || overflow !== 1'b0 || rows_seen !== 16) begin
            bad++; $display("FAIL single_done: done=%b row_valid=%b ovf=%b rows=%0d want 1 0 0 16",
                            done, bus.row_valid, overflow, rows_seen);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL single_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_multi_gaps();
        start_run(8'd3);
        feed_run(3, -5, 1'b0, 1);
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL multi_hdr: in_ready=%b out_valid=%b want 0 1", bus.in_ready, bus.out_valid);
        end
        repeat (17) begin @(posedge clk); #1; end
        total++;
        if (done !== 1'b1 || rows_seen !== 16 || overflow !== 1'b0) begin
            bad++; $display("FAIL multi_done: done=%b rows=%0d ovf=%b want 1 16 0", done, rows_seen, overflow);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        start_run(8'd20);
        feed_run(20, 524287, 1'b0, 0);
        repeat (17) begin @(posedge clk); #1; end
        total++;
        if (done !== 1'b1 || overflow !== 1'b1 || rows_seen !== 16) begin
            bad++; $display("FAIL sat_pos_done: done=%b ovf=%b rows=%0d want 1 1 16", done, overflow, rows_seen);
        end
        @(posedge clk); #1;
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL sat_sticky: ovf got %b want 1", overflow); end
        start_run(8'd20);
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL sat_clear: ovf got %b want 0", overflow); end
        feed_run(20, -524288, 1'b0, 0);
        repeat (17) begin @(posedge clk); #1; end
        total++;
        if (done !== 1'b1 || overflow !== 1'b1 || rows_seen !== 16) begin
            bad++; $display("FAIL sat_neg_done: done=%b ovf=%b rows=%0d want 1 1 16", done, overflow, rows_seen);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_tile0_overwrite();
        start_run(8'd1);
        feed_run(1, 100, 1'b0, 0);
        repeat (18) begin @(posedge clk); #1; end
        start_run(8'd0);
        feed_run(1, 7, 1'b0, 0);
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL zero_tiles_hdr: out_valid got %b want 1", bus.out_valid);
        end
        repeat (17) begin @(posedge clk); #1; end
        total++;
        if (done !== 1'b1 || rows_seen !== 16) begin
            bad++; $display("FAIL zero_tiles_done: done=%b rows=%0d want 1 16", done, rows_seen);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_inputs();
        start_run(8'd2);
        num_tiles = 8'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feed_run(2, 1000, 1'b0, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = {LANES{20'h00123}};
        start = 1'b1;
        num_tiles = 8'd1;
        total++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL ign_hdr: out_valid=%b in_ready=%b want 1 0", bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.in_valid = 1'b0;
        total++;
        if (done !== 1'b1 || rows_seen !== 16) begin
            bad++; $display("FAIL ign_done: done=%b rows=%0d want 1 16", done, rows_seen);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL ign_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        start_run(8'd1);
        feed_run(1, 0, 1'b1, 0);
        repeat (8) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.row_valid, busy, done, overflow} !== 6'b0 ||
            bus.partial_sum !== '0 || rows_seen !== 7) begin
            bad++; $display("FAIL rst_mid_out: flags=%b ps=%h rows=%0d want 000000 0 7",
                            {bus.in_ready, bus.out_valid, bus.row_valid, busy, done, overflow},
                            bus.partial_sum, rows_seen);
        end
        sbq.delete();
        repeat (3) begin
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done: done got %b want 0", done); end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rst_mid_release: busy=%b done=%b want 0 0", busy, done);
        end
        start_run(8'd2);
        feed_run(2, 3, 1'b0, 0);
        repeat (17) begin @(posedge clk); #1; end
        total++;
        if (done !== 1'b1 || rows_seen !== 16) begin
            bad++; $display("FAIL rst_mid_rerun: done=%b rows=%0d want 1 16", done, rows_seen);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_single_tile();
        test_multi_gaps();
        test_saturation();
        test_tile0_overwrite();
        test_ignored_inputs();
        test_reset_mid();
        total++;
        if (sbq.size() != 0) begin
            bad++; $display("FAIL sb_leftover: %0d rows never drained, want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

- Sits directly upstream of the post-processing unit (`ppu`).
- Collects 16-lane signed partial-sum rows from the systolic array over a run-time number of K-tiles and accumulates them, with saturation, into a 16-row × 16-lane int24 buffer.
- When the last tile has been accumulated, streams the buffer as the `ppu` input burst: a one-cycle `out_valid` header, then 16 back-to-back rows on `partial_sum`.

## Interface
- `LANES`, 16: lanes per row; fixed.
- `ROWS`, 16: rows per burst; fixed, matching the `ppu` 16-write input window.
- `IN_W`, 20: signed width of each array lane.
- `ACC_W`, 24: signed accumulator width; `LANES*ACC_W` = 384.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; latches `num_tiles`; honoured only in IDLE.
- `num_tiles`  in  8  K-tiles to accumulate; 0 is treated as 1.
- `in_valid`  in  1  array row beat valid.
- `in_data`  in  `LANES*IN_W` (320)  lane i at `[i*20 +: 20]`, signed.
- `in_ready`  out  1  high only in ACCUM.
- `out_valid`  out  1  one-cycle header pulse; drives `ppu.valid`.
- `partial_sum`  out  384  lane i at `[i*24 +: 24]`; drives `ppu.partial_sum`.
- `row_valid`  out  1  high while `partial_sum` carries a buffer row.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse after the final row is driven.
- `overflow`  out  1  sticky; set on any saturation; cleared by an accepted `start`.

## Operation
States are IDLE, ACCUM, HDR, DRAIN and DONE. Internal counters are `row` (4 bits), `tile` (8 bits) and `tiles_m1` (8 bits).

- **IDLE**
  - On `start`: `tiles_m1 = max(num_tiles,1) - 1`, `row = 0`, `tile = 0`, `overflow` cleared, go to ACCUM.
  - `in_valid` is ignored.
- **ACCUM**
  - An accepted beat (`in_valid && in_ready`) targets `buf[row]`.
  - If `tile == 0`: each lane is written with `sext(in_lane)`. Stale data is never added.
  - Otherwise: each lane is written with `sat24(buf[row][i] + sext(in_lane))`, computed in a 25-bit sum.
    - Result > 0x7FFFFF clamps to 0x7FFFFF.
    - Result < −0x800000 clamps to 0x800000.
    - Either clamp sets `overflow`.
  - After each beat `row` increments. On `row == 15` it wraps to 0 and `tile` increments.
  - On the beat with `row == 15 && tile == tiles_m1`, go to HDR.
  - Cycles with `in_valid == 0` hold all state. Gaps are allowed anywhere.
- **HDR**
  - For one cycle: `out_valid = 1`, `partial_sum = 0`, `row_valid = 0`, `row = 0`.
  - Go to DRAIN.
- **DRAIN**
  - For 16 consecutive cycles: `partial_sum = buf[row]`, `row_valid = 1`, `row` increments.
  - After `row == 15`, go to DONE.
  - The drain cannot be stalled; the downstream `ppu` must be in its IDLE state at the header.
- **DONE**
  - For one cycle: `done = 1`, then go to IDLE.
  - Buffer contents are retained but are overwritten on the next run's tile 0.
- **Precedence and ignored inputs**
  - `start` outside IDLE is ignored: no latch, no `overflow` clear.
  - `in_valid` outside ACCUM is ignored and not accepted.
- **Output register rules**
  - `partial_sum`, `out_valid`, `row_valid` and `done` are registered (driven from state-decoded flops).
  - `partial_sum` is 0 whenever `row_valid == 0`.

## Timing
- **Reset values:** `in_ready`, `out_valid`, `row_valid`, `busy`, `done` and `overflow` are 0; `partial_sum` = 0; the buffer is all zero; state is IDLE.
- **Reset mid-operation:** the run is aborted immediately (asynchronous); no `done` is produced.
- **Start to ACCUM:** `start` sampled at edge t; `in_ready` = 1 from t+1.
- **Last beat to output:** last beat accepted at edge t; `out_valid` is high in cycle t+1; row 0 is on `partial_sum` in cycle t+2; row 15 in t+17; `done` in t+18; `busy` low from t+19.
- **`ppu` alignment:** `ppu` samples `valid` in cycle t+1 and writes rows on its 16 `write_en` cycles t+2..t+17, exactly aligned with the drain.
- **Minimum run:** 1 + 16·N (ACCUM, zero-gap input) + 1 + 16 + 1 cycles.
- **`busy` back-to-back:** `busy` rises the cycle after `start` and falls the cycle after `done`.
- **Back-to-back runs:** the earliest next `start` is the cycle `busy` is low.

## Test plan
- **Single tile:** `num_tiles = 1`; row r lane i = r·16 + i; no gaps. Requirements:
  - `out_valid` one cycle after the 16th beat.
  - `partial_sum` rows equal the inputs sign-extended to 24 bits, in order 0..15.
  - `done` one cycle after row 15.
  - `overflow = 0`.
- **Multi-tile with gaps:** `num_tiles = 3`; every lane = −5 in every tile; `in_valid` toggles every other cycle.
  - All outputs = 0xFFFFF1 (−15).
  - `in_ready` deasserts after the 48th accepted beat.
  - Stalls do not skip or duplicate rows.
- **Saturation:** `num_tiles = 20`; all lanes = 0x7FFFF (524287).
  - Accumulation clamps at 0x7FFFFF.
  - `overflow` = 1 and stays set through `done`.
  - The next `start` clears `overflow`.
  - Repeat with 0x80000 inputs: result 0x800000.
- **Tile-0 overwrite and `num_tiles = 0`:** run with all lanes = 100, then `num_tiles = 0` with all lanes = 7.
  - The second run is treated as 1 tile.
  - Output = 7 on every lane (no residual 100).
- **Ignored inputs:**
  - `start` pulsed during ACCUM and DRAIN, and `in_valid` held high during HDR/DRAIN.
  - Required: no state change, `tile`/`row` unaffected, exactly 16 drain rows.
- **Reset mid-run:** assert `rst_n` low during DRAIN row 7.
  - All outputs are 0 while low.
  - No `done` is produced.
  - A fresh `start` after release completes normally with correct data.
